// File: rtl/vpifo_req_router_if.sv
// ============================================================================
// vpifo_req_router_if : request stream and per-lane issue bus of the PIFO router
// Rev 1.0
// ============================================================================
`default_nettype none

interface vpifo_req_router_if #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4
);
  localparam int DW        = PTW + MTW;
  localparam int TREE_BITS = $clog2(TREE_NUM);

  logic                                req_valid;
  logic                                req_ready;
  logic                                req_push;
  logic [TREE_BITS-1:0]                req_tree_id;
  logic [DW-1:0]                       req_data;
  logic                                req_err;
  logic [LEVEL-1:0]                    push;
  logic [LEVEL-1:0]                    pop;
  logic [LEVEL-1:0][DW-1:0]            push_data;
  logic [LEVEL-1:0][TREE_BITS-1:0]     tree_id;
  logic [LEVEL-1:0]                    task_fifo_full;
  logic [TREE_NUM-1:0]                 tree_empty;

  modport master (
    output req_valid, req_push, req_tree_id, req_data, task_fifo_full,
    input  req_ready, req_err, push, pop, push_data, tree_id, tree_empty
  );

  modport slave (
    input  req_valid, req_push, req_tree_id, req_data, task_fifo_full,
    output req_ready, req_err, push, pop, push_data, tree_id, tree_empty
  );
endinterface

`default_nettype wire

// File: rtl/vpifo_req_router.sv
// ============================================================================
// vpifo_req_router : routes push/pop requests into per-lane queues and issues
//                    them to the tree-top level ports; tracks tree occupancy.
// Rev 1.0
// ============================================================================
`default_nettype none

module vpifo_req_router #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int Q_DEPTH  = 4,
  parameter int OCC_W    = 10
) (
  input  logic                clk,
  input  logic                arst_n,
  vpifo_req_router_if.slave   bus
);
  localparam int DW        = PTW + MTW;
  localparam int LANE_BITS = $clog2(LEVEL);
  localparam int TREE_BITS = $clog2(TREE_NUM);
  localparam int PTR_W     = $clog2(Q_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENTRY_W   = 1 + TREE_BITS + DW;
  localparam logic [OCC_W-1:0] OCC_MAX = '1;

  logic [OCC_W-1:0]     occ [TREE_NUM];
  logic [LANE_BITS-1:0] lane_in;
  logic [OCC_W-1:0]     occ_in;
  logic                 accept;
  logic                 reject;
  logic                 enq_ok;
  logic [LEVEL-1:0]     q_full;
  logic                 err_q;

  assign lane_in       = bus.req_tree_id[LANE_BITS-1:0];
  assign occ_in        = occ[bus.req_tree_id];
  assign bus.req_ready = arst_n && !q_full[lane_in];
  assign accept        = bus.req_valid && bus.req_ready;
  assign reject        = bus.req_push ? (occ_in == OCC_MAX) : (occ_in == '0);
  assign enq_ok        = accept && !reject;
  assign bus.req_err   = err_q;

  always_ff @(posedge clk) begin
    if (!arst_n) err_q <= 1'b0;
    else         err_q <= accept && reject;
  end

  // Occupancy moves at accept time so back-to-back push/pop of one tree is legal.
  generate
    for (genvar t = 0; t < TREE_NUM; t++) begin : g_tree
      always_ff @(posedge clk) begin
        if (!arst_n) begin
          occ[t] <= '0;
        end else if (enq_ok && bus.req_tree_id == TREE_BITS'(t)) begin
          occ[t] <= bus.req_push ? occ[t] + 1'b1 : occ[t] - 1'b1;
        end
      end
      assign bus.tree_empty[t] = (occ[t] == '0);
    end
  endgenerate

  generate
    for (genvar l = 0; l < LEVEL; l++) begin : g_lane
      logic [ENTRY_W-1:0] mem [Q_DEPTH];
      logic [PTR_W-1:0]   rd_ptr;
      logic [PTR_W-1:0]   wr_ptr;
      logic [CNT_W-1:0]   cnt;
      logic               enq;
      logic               deq;
      logic [ENTRY_W-1:0] head;
      logic               push_q;
      logic               pop_q;
      logic [DW-1:0]      data_q;
      logic [TREE_BITS-1:0] id_q;

      assign enq       = enq_ok && (lane_in == LANE_BITS'(l));
      assign q_full[l] = (cnt == CNT_W'(Q_DEPTH));
      assign deq       = (cnt != '0) && !bus.task_fifo_full[l];
      assign head      = mem[rd_ptr];

      always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= {bus.req_push, bus.req_tree_id, bus.req_data};
      end

      always_ff @(posedge clk) begin
        if (!arst_n) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          cnt    <= '0;
          push_q <= 1'b0;
          pop_q  <= 1'b0;
          data_q <= '1;
          id_q   <= '0;
        end else begin
          if (enq) wr_ptr <= wr_ptr + 1'b1;
          if (deq) rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt + CNT_W'(enq) - CNT_W'(deq);
          push_q <= deq && head[ENTRY_W-1];
          pop_q  <= deq && !head[ENTRY_W-1];
          // Pop strobes carry zero data; idle lanes park at all-ones.
          data_q <= deq ? (head[ENTRY_W-1] ? head[DW-1:0] : '0) : '1;
          id_q   <= deq ? head[DW +: TREE_BITS] : '0;
        end
      end

      assign bus.push[l]      = push_q;
      assign bus.pop[l]       = pop_q;
      assign bus.push_data[l] = data_q;
      assign bus.tree_id[l]   = id_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vpifo_req_router.sv
// ============================================================================
// tb_vpifo_req_router : table-driven plus scoreboard bench for vpifo_req_router
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vpifo_req_router;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  vpifo_req_router_if #(.PTW(16), .MTW(0), .LEVEL(4), .TREE_NUM(4)) bus ();

  vpifo_req_router #(
    .PTW(16), .MTW(0), .LEVEL(4), .TREE_NUM(4), .Q_DEPTH(4), .OCC_W(10)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic        push;
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        push;
    logic [1:0]  tree;
    logic [15:0] data;
    logic        exp_err;
    logic        exp_empty;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe is matched against the oldest expected entry of its lane.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.push[l] || bus.pop[l]) begin
          int idx;
          idx = -1;
          chk($sformatf("lane%0d_push_pop_excl", l), {31'b0, bus.push[l] & bus.pop[l]}, 32'd0);
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && int'(sb[i].id) == l) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d_unexpected_strobe: got push=%0b pop=%0b expected no strobe",
                     l, bus.push[l], bus.pop[l]);
          end else begin
            chk($sformatf("lane%0d_strobe_kind", l), {31'b0, bus.push[l]}, {31'b0, sb[idx].push});
            chk($sformatf("lane%0d_data", l), {16'b0, bus.push_data[l]}, {16'b0, sb[idx].data});
            chk($sformatf("lane%0d_id", l), {30'b0, bus.tree_id[l]}, {30'b0, sb[idx].id});
            sb.delete(idx);
          end
        end else begin
          chk($sformatf("lane%0d_idle_data", l), {16'b0, bus.push_data[l]}, 32'h0000FFFF);
          chk($sformatf("lane%0d_idle_id", l), {30'b0, bus.tree_id[l]}, 32'd0);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic p, input logic [1:0] t, input logic [15:0] d,
                      input logic exp_err, input string nm);
    int n;
    bus.req_valid   = 1'b1;
    bus.req_push    = p;
    bus.req_tree_id = t;
    bus.req_data    = d;
    #1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got ready=0 expected 1", nm);
      bus.req_valid = 1'b0;
      return;
    end
    if (!exp_err) sb.push_back('{push: p, id: t, data: (p ? d : 16'h0000)});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_err"}, {31'b0, bus.req_err}, {31'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 2'd1, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 2'd0, 16'hA000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 16'hB001, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 16'hC003, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'd3, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 2'd2, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 2'd2, 16'h0000, 1'b1, 1'b1};

    bus.req_valid      = 1'b0;
    bus.req_push       = 1'b0;
    bus.req_tree_id    = '0;
    bus.req_data       = '0;
    bus.task_fifo_full = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_push", {28'b0, bus.push}, 32'd0);
    chk("rst_pop", {28'b0, bus.pop}, 32'd0);
    chk("rst_err", {31'b0, bus.req_err}, 32'd0);
    chk("rst_empty", {28'b0, bus.tree_empty}, 32'hF);
    for (int l = 0; l < 4; l++) begin
      chk("rst_data", {16'b0, bus.push_data[l]}, 32'h0000FFFF);
      chk("rst_id", {30'b0, bus.tree_id[l]}, 32'd0);
    end

    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    // Minimum latency: strobe two edges after accept, occupancy one.
    send(1'b1, 2'd2, 16'h1234, 1'b0, "push_t2");
    chk("t2_not_empty", {31'b0, bus.tree_empty[2]}, 32'd0);
    chk("t2_no_early_strobe", {31'b0, bus.push[2]}, 32'd0);
    @(negedge clk);
    chk("t2_strobe", {31'b0, bus.push[2]}, 32'd1);

    for (int v = 0; v < 9; v++) begin
      send(vecs[v].push, vecs[v].tree, vecs[v].data, vecs[v].exp_err, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_empty", v), {31'b0, bus.tree_empty[vecs[v].tree]},
          {31'b0, vecs[v].exp_empty});
    end
    repeat (4) @(negedge clk);

    // Lane 0 blocked: fill its queue, confirm back-pressure is lane-local.
    bus.task_fifo_full = 4'b0001;
    for (int i = 0; i < 4; i++)
      send(1'b1, 2'd0, 16'h0100 + 16'(i), 1'b0, $sformatf("fill%0d", i));
    bus.req_valid   = 1'b1;
    bus.req_push    = 1'b1;
    bus.req_tree_id = 2'd0;
    bus.req_data    = 16'h0104;
    #1 chk("q0_full_ready", {31'b0, bus.req_ready}, 32'd0);
    bus.req_tree_id = 2'd1;
    #1 chk("q1_ready_while_q0_full", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    send(1'b1, 2'd1, 16'h0B0B, 1'b0, "push_t1_blocked0");
    @(negedge clk);
    chk("t1_strobe_past_block", {31'b0, bus.push[1]}, 32'd1);
    chk("lane0_silent", {31'b0, bus.push[0]}, 32'd0);

    bus.task_fifo_full = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("q0_burst%0d", i), {31'b0, bus.push[0]}, 32'd1);
    end
    @(negedge clk);
    chk("q0_burst_end", {31'b0, bus.push[0]}, 32'd0);

    // Back-to-back push then pop of tree 3.
    sb.push_back('{push: 1'b1, id: 2'd3, data: 16'h3333});
    sb.push_back('{push: 1'b0, id: 2'd3, data: 16'h0000});
    bus.req_valid   = 1'b1;
    bus.req_push    = 1'b1;
    bus.req_tree_id = 2'd3;
    bus.req_data    = 16'h3333;
    #1 chk("t3_push_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_push = 1'b0;
    bus.req_data = 16'h5555;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t3_push_strobe", {31'b0, bus.push[3]}, 32'd1);
    chk("t3_no_pop_yet", {31'b0, bus.pop[3]}, 32'd0);
    @(negedge clk);
    chk("t3_pop_strobe", {31'b0, bus.pop[3]}, 32'd1);
    chk("t3_no_push", {31'b0, bus.push[3]}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset with three requests parked behind a full lane.
    bus.task_fifo_full = 4'b0100;
    for (int i = 0; i < 3; i++)
      send(1'b1, 2'd2, 16'h2200 + 16'(i), 1'b0, $sformatf("park%0d", i));
    arst_n = 1'b0;
    sb.delete();
    bus.task_fifo_full = 4'b0000;
    repeat (2) @(negedge clk);
    chk("midrst_ready", {31'b0, bus.req_ready}, 32'd0);
    arst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_empty", {28'b0, bus.tree_empty}, 32'hF);
    chk("post_rst_push", {28'b0, bus.push}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
